// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a debounced lock, then releases sys_reset.
// Optional status outputs (retry_count_o, lock_lost_o, lock_lost_clr_i) under PLL_RESET_SEQ_STATUS_EN.
module pll_reset_seq #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 27000,
  parameter int unsigned LOCK_STABLE    = 256,
  parameter int unsigned RESET_HOLD     = 64,
  parameter int unsigned TIMER_W        = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       pll_lock_i,
  output logic       pll_reset_o,
  output logic       sys_reset_o,
  output logic       ready_o
`ifdef PLL_RESET_SEQ_STATUS_EN
  ,
  output logic [7:0] retry_count_o,
  output logic       lock_lost_o,
  input  logic       lock_lost_clr_i
`endif
);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StHold,
    StRun
  } state_e;

  localparam logic [TIMER_W-1:0] RstLast     = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TimeoutLast = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] StableLast  = TIMER_W'(LOCK_STABLE - 1);
  localparam logic [TIMER_W-1:0] HoldLast    = TIMER_W'(RESET_HOLD - 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 sync1_q, sync2_q;
  logic                 lock_s;
  logic                 pll_reset_q, sys_reset_q, ready_q;

  assign lock_s = sync2_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPllRst: begin
        if (timer_q == RstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lock_s)                       state_d = StStable;
        else if (timer_q == TimeoutLast)  state_d = StPllRst;
      end
      StStable: begin
        // Any dropout restarts the lock wait rather than the whole PLL sequence.
        if (!lock_s)                      state_d = StWaitLock;
        else if (timer_q == StableLast)   state_d = StHold;
      end
      StHold: begin
        if (!lock_s)                      state_d = StPllRst;
        else if (timer_q == HoldLast)     state_d = StRun;
      end
      StRun: begin
        if (!lock_s)                      state_d = StPllRst;
      end
      default: state_d = StPllRst;
    endcase

    timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StPllRst;
      timer_q     <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      sync1_q     <= pll_lock_i;
      sync2_q     <= sync1_q;
      pll_reset_q <= (state_d == StPllRst);
      sys_reset_q <= (state_d != StRun);
      ready_q     <= (state_d == StRun);
    end
  end

  assign pll_reset_o = pll_reset_q;
  assign sys_reset_o = sys_reset_q;
  assign ready_o     = ready_q;

`ifdef PLL_RESET_SEQ_STATUS_EN
  logic       timeout_evt, lost_evt;
  logic [7:0] retry_count_q, retry_count_d;
  logic       lock_lost_q, lock_lost_d;

  always_comb begin
    timeout_evt   = (state_q == StWaitLock) && (state_d == StPllRst);
    lost_evt      = ((state_q == StHold) || (state_q == StRun)) && (state_d == StPllRst);
    retry_count_d = retry_count_q;
    if (timeout_evt && (retry_count_q != 8'hFF)) retry_count_d = retry_count_q + 8'd1;
    // A new loss event takes priority over a coincident clear.
    lock_lost_d = lock_lost_q;
    if (lost_evt)             lock_lost_d = 1'b1;
    else if (lock_lost_clr_i) lock_lost_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      retry_count_q <= '0;
      lock_lost_q   <= 1'b0;
    end else begin
      retry_count_q <= retry_count_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign retry_count_o = retry_count_q;
  assign lock_lost_o   = lock_lost_q;
`endif

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Controller-side counterpart to the rPLL wrapper. It drives the PLL RESET input and consumes the PLL LOCK output.
- Runs on the free-running 27 MHz reference clock, not on the PLL output, so it keeps running when lock is lost.
- Pulses the PLL reset, waits for a debounced lock, then releases a synchronous system reset to downstream logic.
- Re-pulses the PLL on lock timeout or lock loss.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_reset is held high per attempt.
- LOCK_TIMEOUT, 27000: cycles to wait for lock (1 ms at 27 MHz) before retrying.
- LOCK_STABLE, 256: consecutive synchronized-lock cycles required before release.
- RESET_HOLD, 64: extra cycles sys_reset stays high after lock is stable.
- TIMER_W, 16: shared counter width. Every cycle parameter must be ≥1 and ≤2^TIMER_W.

Ports:
- clk  in  1  27 MHz reference clock; same net as the PLL CLKIN.
- reset  in  1  synchronous, active-high.
- pll_lock  in  1  PLL LOCK; asynchronous to clk.
- pll_reset  out  1  to PLL RESET; active-high.
- sys_reset  out  1  synchronous active-high reset for downstream logic.
- ready  out  1  equals ~sys_reset; high only in RUN.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high.
- On reset:
  - state=PLL_RST, timer=0.
  - pll_reset=1, sys_reset=1, ready=0.
  - Both synchronizer flops=0.
  - retry_count=0, lock_lost=0.
- Lock synchronizer:
  - pll_lock passes through a 2-FF synchronizer to give lock_s (2-cycle latency).
  - Only lock_s is used internally.
- Timer:
  - Increments each cycle and clears on every state change.
  - A state lasting N cycles exits when timer==N-1.
- Outputs are flops loaded on the same edge as the state register. No combinational outputs.
- States:
  - PLL_RST:
    - pll_reset=1, sys_reset=1.
    - After PLL_RST_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK:
    - pll_reset=0, sys_reset=1.
    - lock_s=1: go to STABLE.
    - Else, if timer==LOCK_TIMEOUT-1: go to PLL_RST and increment retry_count (saturating).
  - STABLE:
    - lock_s=0: go to WAIT_LOCK; the timeout restarts from 0.
    - lock_s=1 held for LOCK_STABLE consecutive cycles: go to HOLD.
  - HOLD:
    - sys_reset=1.
    - lock_s=0: go to PLL_RST.
    - Else, after RESET_HOLD cycles: go to RUN.
  - RUN:
    - sys_reset=0, ready=1.
    - lock_s=0: go to PLL_RST. sys_reset and pll_reset rise on the same edge.
- Precedence: lock_s=0 beats a timer expiry in the same cycle (STABLE, HOLD).
- Nominal release latency from reset deassertion, lock already high:
  - PLL_RST_CYCLES + 1 + LOCK_STABLE + RESET_HOLD cycles.
  - For example, 4+1+8+5=18 cycles with the test parameters.
- Lock-loss response: pll_lock fall to sys_reset rise is ≤3 cycles (2 synchronizer + 1 state).
- Reset mid-operation: any state returns to the reset values above on the next edge.

Optional Feature:
- Macro: PLL_RESET_SEQ_STATUS_EN.
- Defined:
  - Adds output retry_count[7:0]: WAIT_LOCK timeouts, saturating at 255.
  - Adds output lock_lost: sticky; set on any lock_s=0 exit from HOLD or RUN.
  - Adds input lock_lost_clr: clears lock_lost. If set and clear occur in the same cycle, set wins.
  - retry_count clears only on reset.
- Undefined:
  - These three ports and their flops do not exist.
  - Core sequencing is identical.

Test Plan:
(Parameters for all tests: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, RESET_HOLD=5.)
1. Deassert reset with pll_lock=1 constant -> pll_reset=1 for cycles 0-3, 0 from cycle 4; sys_reset falls and ready rises at cycle 18; both stay stable thereafter.
2. pll_lock=0 forever -> pll_reset pulses 4 cycles high every 24 cycles; sys_reset never falls; retry_count reads 1, 2, 3 after the 1st, 2nd, 3rd timeout and saturates at 255.
3. pll_lock=1, drop it for 1 cycle while in STABLE -> state returns to WAIT_LOCK, STABLE count restarts; sys_reset release is delayed by the elapsed STABLE cycles plus 1; pll_reset stays 0.
4. In RUN, drop pll_lock -> within 3 cycles sys_reset=1, ready=0, pll_reset=1 for 4 cycles, lock_lost=1; with lock restored, release again 18 cycles after re-entering PLL_RST.
5. Assert reset for 1 cycle while in HOLD -> next edge: pll_reset=1, sys_reset=1, retry_count=0, lock_lost=0; full sequence restarts from cycle 0.
6. lock_lost=1, pulse lock_lost_clr -> lock_lost=0 next cycle. Lock loss in RUN coinciding with a lock_lost_clr pulse -> lock_lost=1.
